// File: rtl/coletor_palpite.sv
// coletor_palpite -- collects a multi-digit guess one confirmed digit at a time.
//
// A digit is sampled from `digito` on each `borda_subida` pulse while the
// collector is in COLETA. Digits above MAX_DIGITO, or equal to a digit already
// stored in the current guess, are rejected with a one-cycle `erro` pulse.
// Once NUM_DIGITOS digits are stored, the guess is offered on `palpite` with
// `palpite_valido` until the consumer raises `palpite_pronto`. A single ENTREGA
// cycle follows, then the guess is cleared and collection restarts.
//
// Ports
//   clock          in   single clock, rising edge
//   reset          in   asynchronous, active-high
//   borda_subida   in   one-cycle confirm pulse (debounced button edge)
//   digito[3:0]    in   switch value sampled on borda_subida
//   palpite_pronto in   consumer ready; transfer when high with palpite_valido
//   palpite[15:0]  out  guess, first digit in [15:12], last in [3:0]
//   palpite_valido out  full guess available
//   erro           out  one-cycle pulse per rejected entry
//   posicao[1:0]   out  digits stored so far while collecting
module coletor_palpite #(
    parameter int MAX_DIGITO  = 9,
    parameter int NUM_DIGITOS = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     borda_subida,
    input  logic [3:0]               digito,
    input  logic                     palpite_pronto,
    output logic [4*NUM_DIGITOS-1:0] palpite,
    output logic                     palpite_valido,
    output logic                     erro,
    output logic [1:0]               posicao
);

    typedef enum logic [1:0] {
        COLETA  = 2'd0,
        CHEIO   = 2'd1,
        ENTREGA = 2'd2
    } estado_t;

    estado_t                  estado_q, estado_d;
    logic [4*NUM_DIGITOS-1:0] palpite_q, palpite_d;
    logic                     valido_q, valido_d;
    logic                     erro_q, erro_d;
    logic [1:0]               posicao_q, posicao_d;

    logic fora_faixa;
    logic duplicado;

    always_comb begin
        // Only positions already filled take part in the duplicate check, so
        // the zeroed nibbles of an empty guess never reject a leading 0.
        duplicado = 1'b0;
        for (int i = 0; i < NUM_DIGITOS; i++) begin
            if (2'(i) < posicao_q && palpite_q[4*(NUM_DIGITOS-1-i) +: 4] == digito)
                duplicado = 1'b1;
        end
        fora_faixa = {28'd0, digito} > 32'(MAX_DIGITO);

        estado_d  = estado_q;
        palpite_d = palpite_q;
        valido_d  = valido_q;
        erro_d    = 1'b0;
        posicao_d = posicao_q;

        case (estado_q)
            COLETA: begin
                valido_d = 1'b0;
                if (borda_subida) begin
                    if (fora_faixa || duplicado) begin
                        erro_d = 1'b1;
                    end else begin
                        for (int i = 0; i < NUM_DIGITOS; i++) begin
                            if (2'(i) == posicao_q)
                                palpite_d[4*(NUM_DIGITOS-1-i) +: 4] = digito;
                        end
                        if (posicao_q == 2'(NUM_DIGITOS-1)) begin
                            estado_d  = CHEIO;
                            valido_d  = 1'b1;
                            posicao_d = 2'd0;
                        end else begin
                            posicao_d = posicao_q + 2'd1;
                        end
                    end
                end
            end
            CHEIO: begin
                // Confirm pulses are ignored here; only the consumer moves us on.
                valido_d = 1'b1;
                if (palpite_pronto) begin
                    estado_d = ENTREGA;
                    valido_d = 1'b0;
                end
            end
            ENTREGA: begin
                estado_d  = COLETA;
                palpite_d = '0;
                valido_d  = 1'b0;
                posicao_d = 2'd0;
            end
            default: begin
                // Unused encoding: fall back to a clean, empty collector.
                estado_d  = COLETA;
                palpite_d = '0;
                valido_d  = 1'b0;
                posicao_d = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q  <= COLETA;
            palpite_q <= '0;
            valido_q  <= 1'b0;
            erro_q    <= 1'b0;
            posicao_q <= 2'd0;
        end else begin
            estado_q  <= estado_d;
            palpite_q <= palpite_d;
            valido_q  <= valido_d;
            erro_q    <= erro_d;
            posicao_q <= posicao_d;
        end
    end

    assign palpite        = palpite_q;
    assign palpite_valido = valido_q;
    assign erro           = erro_q;
    assign posicao        = posicao_q;

endmodule

// File: tb/tb_coletor_palpite.sv
module tb_coletor_palpite;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        borda_subida = 1'b0;
    logic [3:0]  digito = 4'd0;
    logic        palpite_pronto = 1'b0;
    logic [15:0] palpite;
    logic        palpite_valido;
    logic        erro;
    logic [1:0]  posicao;

    int vectors = 0;
    int miscompares = 0;
    int valid_cnt = 0;
    logic prev_v = 1'b0;
    logic [15:0] exp_q[$];

    coletor_palpite #(.MAX_DIGITO(9), .NUM_DIGITOS(4)) dut (
        .clock          (clock),
        .reset          (reset),
        .borda_subida   (borda_subida),
        .digito         (digito),
        .palpite_pronto (palpite_pronto),
        .palpite        (palpite),
        .palpite_valido (palpite_valido),
        .erro           (erro),
        .posicao        (posicao)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Scoreboard: every rising edge of palpite_valido must present the next
    // expected guess.
    always @(negedge clock) begin
        if (!reset) begin
            if (palpite_valido) valid_cnt++;
            if (palpite_valido && !prev_v) begin
                if (exp_q.size() == 0) chk("sb_unexpected_guess", {16'd0, palpite}, 32'hFFFF_FFFF);
                else chk("sb_palpite", {16'd0, palpite}, {16'd0, exp_q.pop_front()});
            end
        end
        prev_v = palpite_valido;
    end

    // One confirm pulse; returns on the negedge where its result is visible.
    task automatic pulse(input logic [3:0] d);
        @(negedge clock);
        borda_subida = 1'b1;
        digito = d;
        @(negedge clock);
        borda_subida = 1'b0;
    endtask

    // Consumer accepts the guess; checks ENTREGA then the cleared COLETA.
    task automatic deliver(input string tag);
        palpite_pronto = 1'b1;
        @(negedge clock);
        palpite_pronto = 1'b0;
        chk({tag, "_valido_drop"}, {31'd0, palpite_valido}, 32'd0);
        @(negedge clock);
        chk({tag, "_palpite_clr"}, {16'd0, palpite}, 32'd0);
        chk({tag, "_posicao_clr"}, {30'd0, posicao}, 32'd0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clock);
        chk("rst_palpite", {16'd0, palpite}, 32'd0);
        chk("rst_valido", {31'd0, palpite_valido}, 32'd0);
        chk("rst_erro", {31'd0, erro}, 32'd0);
        chk("rst_posicao", {30'd0, posicao}, 32'd0);
        reset = 1'b0;

        // 1,2,3,4 held in CHEIO for 10 cycles
        exp_q.push_back(16'h1234);
        pulse(4'd1); chk("s1_pos1", {30'd0, posicao}, 32'd1);
        pulse(4'd2); chk("s1_pos2", {30'd0, posicao}, 32'd2);
        pulse(4'd3); chk("s1_pos3", {30'd0, posicao}, 32'd3);
        chk("s1_not_valid_yet", {31'd0, palpite_valido}, 32'd0);
        pulse(4'd4);
        chk("s1_latency", {31'd0, palpite_valido}, 32'd1);
        chk("s1_pos_wrap", {30'd0, posicao}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk("s1_hold_palpite", {16'd0, palpite}, 32'h1234);
            chk("s1_hold_valido", {31'd0, palpite_valido}, 32'd1);
        end
        deliver("s1");

        // 5,5 duplicate then 6,7,8
        exp_q.push_back(16'h5678);
        pulse(4'd5);
        pulse(4'd5);
        chk("s2_dup_erro", {31'd0, erro}, 32'd1);
        chk("s2_dup_pos", {30'd0, posicao}, 32'd1);
        @(negedge clock);
        chk("s2_erro_one_cycle", {31'd0, erro}, 32'd0);
        pulse(4'd6); pulse(4'd7); pulse(4'd8);
        chk("s2_valido", {31'd0, palpite_valido}, 32'd1);
        deliver("s2");

        // Out of range, leading 0, back-to-back duplicate rejects
        exp_q.push_back(16'h0123);
        pulse(4'hA);
        chk("s3_range_erro", {31'd0, erro}, 32'd1);
        chk("s3_range_pos", {30'd0, posicao}, 32'd0);
        chk("s3_range_palpite", {16'd0, palpite}, 32'd0);
        pulse(4'd0);
        chk("s3_zero_ok", {31'd0, erro}, 32'd0);
        chk("s3_zero_pos", {30'd0, posicao}, 32'd1);
        @(negedge clock);
        borda_subida = 1'b1; digito = 4'd0;
        @(negedge clock);
        chk("s3_b2b_erro1", {31'd0, erro}, 32'd1);
        @(negedge clock);
        borda_subida = 1'b0;
        chk("s3_b2b_erro2", {31'd0, erro}, 32'd1);
        chk("s3_b2b_pos", {30'd0, posicao}, 32'd1);
        pulse(4'd1); pulse(4'd2); pulse(4'd3);
        deliver("s3");

        // 9012, extra pulse ignored in CHEIO
        exp_q.push_back(16'h9012);
        pulse(4'd9); pulse(4'd0); pulse(4'd1); pulse(4'd2);
        pulse(4'd3);
        chk("s4_ign_erro", {31'd0, erro}, 32'd0);
        chk("s4_ign_valido", {31'd0, palpite_valido}, 32'd1);
        chk("s4_ign_palpite", {16'd0, palpite}, 32'h9012);
        deliver("s4");

        // Asynchronous reset mid-guess
        pulse(4'd7); pulse(4'd3);
        chk("s5_pre_pos", {30'd0, posicao}, 32'd2);
        #2 reset = 1'b1;
        #1;
        chk("s5_async_palpite", {16'd0, palpite}, 32'd0);
        chk("s5_async_pos", {30'd0, posicao}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        exp_q.push_back(16'h7312);
        pulse(4'd7); chk("s5_e7", {31'd0, erro}, 32'd0);
        pulse(4'd3); chk("s5_e3", {31'd0, erro}, 32'd0);
        pulse(4'd1); chk("s5_e1", {31'd0, erro}, 32'd0);
        pulse(4'd2); chk("s5_e2", {31'd0, erro}, 32'd0);
        deliver("s5");

        // Consumer always ready: valid for exactly one cycle
        valid_cnt = 0;
        palpite_pronto = 1'b1;
        exp_q.push_back(16'h2468);
        pulse(4'd2); pulse(4'd4); pulse(4'd6); pulse(4'd8);
        repeat (4) @(negedge clock);
        palpite_pronto = 1'b0;
        chk("s6_valid_cycles", 32'(valid_cnt), 32'd1);
        chk("s6_palpite_clr", {16'd0, palpite}, 32'd0);

        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
